// File: rtl/compositor_pkg.sv
// rtl/compositor_pkg.sv - scanline compositor constants and state encoding
// Purpose: line geometry, sheet geometry, pixel width and FSM states.
// Ports: none (package).
package compositor_pkg;

  localparam int LINE_WIDTH = 1200;
  localparam int SHEET_W    = 2448;
  localparam int PIXEL_W    = 2;
  localparam int ADDR_W     = 19;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    SCAN,
    DRAW,
    DRAIN
  } state_t;

endpackage

// File: rtl/runner_pkg.sv
// rtl/runner_pkg.sv - render-slot types shared between game logic and the compositor
// Purpose: sheet rectangle and screen position carried in each render slot.
// Ports: none (package).
package runner_pkg;

  localparam int RENDER_SLOTS = 32;

  // Rectangle in the sprite sheet, all fields unsigned pixels.
  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
    logic [11:0] w;
    logic [11:0] h;
  } sprite_t;

  // Screen position; both fields are two's-complement so sprites can hang off the edges.
  typedef struct packed {
    logic [11:0] x;
    logic [11:0] y;
  } pos_t;

endpackage

// File: rtl/scanline_compositor_if.sv
// rtl/scanline_compositor_if.sv - line request, sheet ROM and pixel read signals
// Purpose: bundles the compositor's handshake/bus signals.
// Ports: line_start/line_y in, busy/overrun out, rom_addr out / rom_rdata in,
//        pix_x in / pix_data out (directions as seen by the compositor, modport slave).
interface scanline_compositor_if #(
  parameter int PIXEL_W = compositor_pkg::PIXEL_W,
  parameter int ADDR_W  = compositor_pkg::ADDR_W
);
  logic               line_start;
  logic [11:0]        line_y;
  logic               busy;
  logic               overrun;
  logic [ADDR_W-1:0]  rom_addr;
  logic [PIXEL_W-1:0] rom_rdata;
  logic [10:0]        pix_x;
  logic [PIXEL_W-1:0] pix_data;

  modport master (
    output line_start, line_y, rom_rdata, pix_x,
    input  busy, overrun, rom_addr, pix_data
  );

  modport slave (
    input  line_start, line_y, rom_rdata, pix_x,
    output busy, overrun, rom_addr, pix_data
  );
endinterface

// File: rtl/line_buffer.sv
// rtl/line_buffer.sv - ping-pong scanline buffer
// Purpose: two banks of LINE_WIDTH pixels; writes go to the back bank (bank_sel),
//          registered reads come from the front bank (~bank_sel).
// Ports: clk, rst_n, bank_sel, front_valid, wr_en/wr_addr/wr_data, rd_addr, rd_data.
module line_buffer #(
  parameter int LINE_WIDTH = 1200,
  parameter int PIXEL_W    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               bank_sel,
  input  logic               front_valid,
  input  logic               wr_en,
  input  logic [10:0]        wr_addr,
  input  logic [PIXEL_W-1:0] wr_data,
  input  logic [10:0]        rd_addr,
  output logic [PIXEL_W-1:0] rd_data
);

  logic [PIXEL_W-1:0] bank0 [LINE_WIDTH];
  logic [PIXEL_W-1:0] bank1 [LINE_WIDTH];

  // Storage is deliberately not reset; the clear pass owns its contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (bank_sel) bank1[wr_addr] <= wr_data;
      else          bank0[wr_addr] <= wr_data;
    end
  end

  // Front bank is the one not being written. Out-of-line indices and a
  // never-completed front both read as 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (!front_valid || rd_addr >= 11'(LINE_WIDTH)) begin
      rd_data <= '0;
    end else begin
      rd_data <= bank_sel ? bank0[rd_addr] : bank1[rd_addr];
    end
  end

endmodule

// File: rtl/scanline_compositor.sv
// rtl/scanline_compositor.sv - composites render slots into a ping-pong scanline
// Purpose: on line_start, clears the back line, walks every slot in index order,
//          fetches intersecting sheet-row pixels from the ROM and writes the
//          non-transparent ones; the finished line becomes the front on the next request.
// Ports: clk, rst_n, sprite[SLOTS], pos[SLOTS], io (slave: line request, ROM, pixel read).
module scanline_compositor
  import runner_pkg::*;
#(
  parameter int SLOTS      = RENDER_SLOTS,
  parameter int LINE_WIDTH = compositor_pkg::LINE_WIDTH,
  parameter int SHEET_W    = compositor_pkg::SHEET_W,
  parameter int PIXEL_W    = compositor_pkg::PIXEL_W,
  parameter int ADDR_W     = compositor_pkg::ADDR_W
) (
  input  logic    clk,
  input  logic    rst_n,
  input  sprite_t sprite [SLOTS],
  input  pos_t    pos    [SLOTS],
  scanline_compositor_if.slave io
);
  import compositor_pkg::state_t;
  import compositor_pkg::IDLE;
  import compositor_pkg::CLEAR;
  import compositor_pkg::SCAN;
  import compositor_pkg::DRAW;
  import compositor_pkg::DRAIN;

  localparam int SLOT_W = $clog2(SLOTS);

  state_t state, state_nxt;

  logic [SLOT_W-1:0] slot;
  logic [10:0]       clr_addr;
  logic [11:0]       ly_q;
  logic [11:0]       spr_x_q, spr_y_q, spr_w_q, pos_x_q;
  logic [11:0]       r_q, c_q;
  logic              p_vld;
  logic [11:0]       p_x;
  logic              bank_sel, front_valid, done_once, ovr_q;

  // Slot currently under inspection in SCAN.
  sprite_t in_spr;
  pos_t    in_pos;
  assign in_spr = sprite[slot];
  assign in_pos = pos[slot];

  // Vertical hit test widened to 14 bits so pos.y + h cannot wrap.
  logic signed [13:0] y_top, y_end, y_cur;
  logic               hit, last_slot, last_col;
  assign y_top     = {{2{in_pos.y[11]}}, in_pos.y};
  assign y_end     = y_top + {2'b00, in_spr.h};
  assign y_cur     = {2'b00, ly_q};
  assign hit       = (in_spr.w != '0) && (in_spr.h != '0) && (y_top <= y_cur) && (y_cur < y_end);
  assign last_slot = (slot == SLOT_W'(SLOTS - 1));
  assign last_col  = (c_q == spr_w_q - 12'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (io.line_start) state_nxt = CLEAR;
      CLEAR:   if (clr_addr == 11'(LINE_WIDTH - 1)) state_nxt = SCAN;
      SCAN: begin
        if (hit)            state_nxt = DRAW;
        else if (last_slot) state_nxt = IDLE;
      end
      DRAW:    if (last_col) state_nxt = DRAIN;
      DRAIN:   state_nxt = last_slot ? IDLE : SCAN;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot        <= '0;
      clr_addr    <= '0;
      ly_q        <= '0;
      spr_x_q     <= '0;
      spr_y_q     <= '0;
      spr_w_q     <= '0;
      pos_x_q     <= '0;
      r_q         <= '0;
      c_q         <= '0;
      p_vld       <= 1'b0;
      p_x         <= '0;
      bank_sel    <= 1'b0;
      front_valid <= 1'b0;
      done_once   <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      ovr_q <= io.line_start && (state != IDLE);
      // Column/screen-x pipeline lines up with the ROM's one-cycle return.
      p_vld <= (state == DRAW);
      p_x   <= pos_x_q + c_q;
      if (state != IDLE && state_nxt == IDLE) done_once <= 1'b1;
      case (state)
        IDLE: begin
          if (io.line_start) begin
            ly_q        <= io.line_y;
            bank_sel    <= ~bank_sel;
            front_valid <= done_once;
            clr_addr    <= '0;
          end
        end
        CLEAR: begin
          clr_addr <= clr_addr + 11'd1;
          slot     <= '0;
        end
        SCAN: begin
          // Latch the slot so later input changes cannot tear it.
          spr_x_q <= in_spr.x;
          spr_y_q <= in_spr.y;
          spr_w_q <= in_spr.w;
          pos_x_q <= in_pos.x;
          r_q     <= ly_q - in_pos.y;
          c_q     <= '0;
          if (!hit) slot <= slot + SLOT_W'(1);
        end
        DRAW:    c_q  <= c_q + 12'd1;
        DRAIN:   slot <= slot + SLOT_W'(1);
        default: ;
      endcase
    end
  end

  logic [ADDR_W-1:0] row_a;
  always_comb begin
    row_a       = ADDR_W'(spr_y_q) + ADDR_W'(r_q);
    io.rom_addr = '0;
    if (state == DRAW)
      io.rom_addr = row_a * ADDR_W'(SHEET_W) + ADDR_W'(spr_x_q) + ADDR_W'(c_q);
  end

  // Clear pass and pixel writes never overlap: p_vld is only set after DRAW.
  logic               wr_en;
  logic [10:0]        wr_addr;
  logic [PIXEL_W-1:0] wr_data;
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = clr_addr;
    wr_data = '0;
    if (state == CLEAR) begin
      wr_en = 1'b1;
    end else if (p_vld && io.rom_rdata != '0 && !p_x[11] && p_x < 12'(LINE_WIDTH)) begin
      wr_en   = 1'b1;
      wr_addr = p_x[10:0];
      wr_data = io.rom_rdata;
    end
  end

  assign io.busy    = (state != IDLE);
  assign io.overrun = ovr_q;

  line_buffer #(
    .LINE_WIDTH (LINE_WIDTH),
    .PIXEL_W    (PIXEL_W)
  ) u_line_buffer (
    .clk         (clk),
    .rst_n       (rst_n),
    .bank_sel    (bank_sel),
    .front_valid (front_valid),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .rd_addr     (io.pix_x),
    .rd_data     (io.pix_data)
  );

endmodule
